data_mem_slave: RTL
===================

# data_mem_slave

Word-addressed data SRAM that sits on the far side of the single-cycle MIPS data-memory port. It answers the processor's CEN/WEN/OEN/A/write-data strobes with combinational read data and clocked writes. After every reset it sweeps the whole array to zero and raises `ready` only when the sweep is complete. Optional access counters and a sticky error flag support bench-level checking.

## Interface
Parameters:
- `AW`, 7, address width in words; depth is 2^AW.
- `DW`, 32, data width.
- `CNT_W`, 16, width of each access counter (used only when `DMEM_STATS_EN` is defined).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `CEN`  in  1  chip enable, active-low; 0 = access this cycle.
- `WEN`  in  1  write enable, active-low; 0 = write, 1 = read (qualified by `CEN`=0).
- `OEN`  in  1  output enable, active-low; gates `ReadDataMem`.
- `A`  in  AW  word address.
- `ReadData2`  in  DW  write data from the processor.
- `ReadDataMem`  out  DW  read data to the processor.
- `ready`  out  1  1 once the clear sweep has finished.
- `err`  out  1  sticky flag: an access was attempted while `ready`=0.
- `rd_cnt`  out  CNT_W  accepted-read count (only when `DMEM_STATS_EN` is defined).
- `wr_cnt`  out  CNT_W  accepted-write count (only when `DMEM_STATS_EN` is defined).

## Operation
- Storage: 2^AW x DW array. The array has no reset of its own; it is zeroed by the sweep.
- FSM, two states:
  - CLEAR: entered on reset. A clear pointer `cp` (AW bits) starts at 0. On each rising edge, `mem[cp]` is written to 0 and `cp` increments. On the edge where `cp` == 2^AW-1, the FSM moves to READY.
  - READY: terminal state; only reset leaves it.
- Read: `CEN`=0, `WEN`=1, `OEN`=0 and READY. `ReadDataMem` = `mem[A]`, combinational (same cycle).
- In every other case `ReadDataMem` = 0. This includes writes, idle cycles, `OEN`=1, and the CLEAR state.
- Write: `CEN`=0, `WEN`=0 and READY. `mem[A]` is written with `ReadData2` on the rising edge. `OEN` does not affect writes.
- Access during CLEAR: `CEN`=0 while in CLEAR. The access is dropped: no array write and no counter change. `err` is set to 1 on that edge.
- `err` is cleared only by reset.
- Address: `A` is used as-is. No wrap logic is needed because every value of `A` is a valid word.

## Timing
- Reset values: `ready`=0, `err`=0, `ReadDataMem`=0, `rd_cnt`=0, `wr_cnt`=0, state=CLEAR, `cp`=0.
- Clear latency: `ready` becomes 1 after the 2^AW-th rising edge following `rst_n` deassertion (128 edges with defaults). It is registered, so there are no glitches.
- Read latency: 0 cycles. Data follows `A` combinationally within the same cycle.
- Write-to-read: a write on edge N is visible to a read of the same address in cycle N+1.
- Back-to-back writes to the same address: the last one wins.
- Reset asserted mid-sweep: the FSM returns to CLEAR with `cp`=0 and the sweep restarts from word 0. Words already cleared stay 0.
- Reset asserted in READY: the full sweep is repeated and all data is lost.
- Integration rule: the processor side must be held off, e.g. by a bench-held reset, until `ready`=1. This block provides no stall output.

## Configuration
- Macro `DMEM_STATS_EN`.
- Defined:
  - `rd_cnt` increments on each accepted read, sampled at the rising edge.
  - `wr_cnt` increments on each accepted write.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - Both reset to 0 asynchronously.
  - Dropped CLEAR-state accesses and idle cycles are not counted.
- Not defined: the counters and the `rd_cnt`/`wr_cnt` ports are absent. All other behaviour is unchanged.

## Test plan
- Reset sweep: hold `rst_n`=0 for 3 cycles, release, and keep `CEN`=1. Required: `ready`=0 through edge 127 and `ready`=1 after edge 128. Then reading A=0, 5 and 127 all return 0x00000000.
- Write/read: in READY, write A=7 with 0xDEADBEEF, next cycle read A=7 with `OEN`=0. Required: `ReadDataMem`=0xDEADBEEF. With `OEN`=1 on the same read, `ReadDataMem`=0.
- Access during CLEAR: at cycle 10 after reset release, write A=3 with 0x12345678. Required: `err`=1 from the next edge. After `ready`, A=3 reads 0, and with the macro defined `wr_cnt`=0.
- Reset mid-sweep: release reset, reassert at cycle 60, release again. Required: `ready` rises exactly 128 edges after the second release, and `err`=0.
- Counters (`DMEM_STATS_EN`, CNT_W=4): perform 20 reads and 3 writes in READY. Required: `rd_cnt`=15 (saturated) and `wr_cnt`=3. Reset returns both to 0.
- Overwrite: write A=127 with 0x1, then with 0x2 on consecutive edges, then read A=127. Required: 0x00000002. A=126 still reads 0.

Source files
------------

// File: rtl/data_mem_slave.sv
// Word-addressed data SRAM for the MIPS data port; zero-sweeps after reset.
// Optional access counters are enabled by defining DMEM_STATS_EN.
module data_mem_slave #(
  parameter int AW    = 7,
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          CEN,
  input  logic          WEN,
  input  logic          OEN,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] ReadData2,
  output logic [DW-1:0] ReadDataMem,
  output logic          ready,
  output logic          err
`ifdef DMEM_STATS_EN
  ,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
`endif
);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;
  localparam logic [AW-1:0] CP_LAST = {AW{1'b1}};

  if (AW < 1 || DW < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("data_mem_slave: bad parameters");
  end

  logic [0:0]    state;
  logic [AW-1:0] cp;
  logic [DW-1:0] mem [2**AW];

  logic sweeping;
  logic rd_acc;
  logic wr_acc;

  assign sweeping = (state == S_CLEAR);
  assign ready    = (state == S_READY);
  assign rd_acc   = ready && !CEN && WEN && !OEN;
  assign wr_acc   = ready && !CEN && !WEN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR;
      cp    <= '0;
    end else if (sweeping) begin
      cp <= cp + 1'b1;
      if (cp == CP_LAST) begin
        state <= S_READY;
      end
    end
  end

  // Array carries no reset; the sweep is the only way it is zeroed.
  always_ff @(posedge clk) begin
    if (sweeping) begin
      mem[cp] <= '0;
    end else if (wr_acc) begin
      mem[A] <= ReadData2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (sweeping && !CEN) begin
      err <= 1'b1;
    end
  end

  always_comb begin
    ReadDataMem = '0;
    if (rd_acc) begin
      ReadDataMem = mem[A];
    end
  end

`ifdef DMEM_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
    end else if (rd_acc && rd_cnt != CNT_MAX) begin
      rd_cnt <= rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
    end else if (wr_acc && wr_cnt != CNT_MAX) begin
      wr_cnt <= wr_cnt + 1'b1;
    end
  end
`endif

endmodule
